// File: rtl/uart_bus_arbiter_if.sv
// Shared-bus interface between the requesting masters, the arbiter
// and the UART slave port.
interface uart_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
);
  logic [NUM_MASTERS-1:0]        m_rd_en_i;
  logic [NUM_MASTERS-1:0]        m_wr_en_i;
  logic [NUM_MASTERS*ADDR_W-1:0] m_address_i;
  logic [NUM_MASTERS*DATA_W-1:0] m_write_data_i;
  logic [NUM_MASTERS-1:0]        m_response_o;
  logic [DATA_W-1:0]             m_read_data_o;
  logic [NUM_MASTERS-1:0]        m_overrun_o;
  logic                          s_rd_en_o;
  logic                          s_wr_en_o;
  logic [ADDR_W-1:0]             s_address_o;
  logic [DATA_W-1:0]             s_write_data_o;
  logic                          s_response_i;
  logic [DATA_W-1:0]             s_read_data_i;

  modport slave (
    input  m_rd_en_i, m_wr_en_i,
    input  m_address_i, m_write_data_i,
    input  s_response_i, s_read_data_i,
    output m_response_o, m_read_data_o,
    output m_overrun_o,
    output s_rd_en_o, s_wr_en_o,
    output s_address_o, s_write_data_o
  );

  modport master (
    output m_rd_en_i, m_wr_en_i,
    output m_address_i, m_write_data_i,
    output s_response_i, s_read_data_i,
    input  m_response_o, m_read_data_o,
    input  m_overrun_o,
    input  s_rd_en_o, s_wr_en_o,
    input  s_address_o, s_write_data_o
  );
endinterface

// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter sharing the UART slave port between masters.
// One transaction in flight; per-master single-entry pending slots.
module uart_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_bus_arbiter_if.slave  bus
);
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  typedef logic [IW-1:0] idx_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] pend_q, kind_q, ovr_q;
  logic [ADDR_W-1:0]      addr_q [NUM_MASTERS];
  logic [DATA_W-1:0]      data_q [NUM_MASTERS];
  idx_t                   gnt_q, gnt_d, last_q, last_d;
  logic [ADDR_W-1:0]      sa_q, sa_d;
  logic [DATA_W-1:0]      sd_q, sd_d;
  logic [NUM_MASTERS-1:0] resp_q, resp_d, clr;
  logic [DATA_W-1:0]      rd_q, rd_d;
  logic                   found;
  idx_t                   pick;

  // Rotating priority search starting just after the last grant.
  always_comb begin
    int   j;
    idx_t jj;
    found = 1'b0;
    pick  = last_q;
    j     = 0;
    jj    = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      j  = (int'(last_q) + k) % NUM_MASTERS;
      jj = idx_t'(j);
      if (!found && pend_q[jj]) begin
        found = 1'b1;
        pick  = jj;
      end
    end
  end

  // Next-state and datapath updates of the transaction FSM.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    sa_d    = sa_q;
    sd_d    = sd_q;
    resp_d  = '0;
    rd_d    = rd_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = pick;
          sa_d    = addr_q[pick];
          sd_d    = data_q[pick];
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_RESP;
      WAIT_RESP: begin
        if (bus.s_response_i) begin
          resp_d[gnt_q] = 1'b1;
          rd_d          = bus.s_read_data_i;
          clr[gnt_q]    = 1'b1;
          last_d        = gnt_q;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, grant bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= idx_t'(NUM_MASTERS - 1);
      sa_q    <= '0;
      sd_q    <= '0;
      resp_q  <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      sa_q    <= sa_d;
      sd_q    <= sd_d;
      resp_q  <= resp_d;
      rd_q    <= rd_d;
    end
  end

  // Pending slot capture, completion clear and sticky overrun flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
      kind_q <= '0;
      ovr_q  <= '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if ((bus.m_rd_en_i[i] | bus.m_wr_en_i[i]) && pend_q[i])
          ovr_q[i] <= 1'b1;
        if ((bus.m_rd_en_i[i] | bus.m_wr_en_i[i]) && !pend_q[i]) begin
          pend_q[i] <= 1'b1;
          kind_q[i] <= bus.m_rd_en_i[i];
          addr_q[i] <= bus.m_address_i[i*ADDR_W +: ADDR_W];
          data_q[i] <= bus.m_write_data_i[i*DATA_W +: DATA_W];
        end else if (clr[i]) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.s_rd_en_o      = (state_q == ISSUE) &  kind_q[gnt_q];
  assign bus.s_wr_en_o      = (state_q == ISSUE) & ~kind_q[gnt_q];
  assign bus.s_address_o    = sa_q;
  assign bus.s_write_data_o = sd_q;
  assign bus.m_response_o   = resp_q;
  assign bus.m_read_data_o  = rd_q;
  assign bus.m_overrun_o    = ovr_q;
endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Self-checking bench for uart_bus_arbiter with a
// transaction-level round-robin reference model.
module tb_uart_bus_arbiter;
  localparam int N = 2;
  localparam int A = 32;
  localparam int D = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_bus_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(A), .DATA_W(D)) bus();

  uart_bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(A), .DATA_W(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model
  int          cyc = 0;
  bit          busy;
  int          owner, g_edge, resp_edge, last;
  bit [N-1:0]  mp, mk, mov, mresp;
  logic [A-1:0] ma [N];
  logic [D-1:0] md [N];
  logic [A-1:0] esa;
  logic [D-1:0] esd, erd;
  int          grants[$];

  // bench-side UART stub controls
  bit          hold = 0, rfix = 0, spur = 0;
  logic [D-1:0] rval = '0;
  int          dut_wr = 0, dut_resp = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit [N-1:0] old;
    cyc++;
    if (!rst_n) begin
      busy = 0; mp = '0; mk = '0; mov = '0; mresp = '0;
      last = N - 1; owner = 0; g_edge = 0; resp_edge = 0;
      esa = '0; esd = '0; erd = '0;
      return;
    end
    old   = mp;
    mresp = '0;
    if (busy) begin
      if (bus.s_response_i && cyc >= g_edge + 2) begin
        mresp[owner] = 1'b1;
        erd          = bus.s_read_data_i;
        mp[owner]    = 1'b0;
        last         = owner;
        busy         = 0;
      end
    end else if (old != '0) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (last + k) % N;
        if (!busy && old[j]) begin
          busy      = 1;
          owner     = j;
          g_edge    = cyc;
          resp_edge = cyc + 2 + int'($urandom_range(0, 3));
          esa       = ma[j];
          esd       = md[j];
          grants.push_back(j);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (bus.m_rd_en_i[i] || bus.m_wr_en_i[i]) begin
        if (old[i]) mov[i] = 1'b1;
        else begin
          mp[i] = 1'b1;
          mk[i] = bus.m_rd_en_i[i];
          ma[i] = bus.m_address_i[i*A +: A];
          md[i] = bus.m_write_data_i[i*D +: D];
        end
      end
    end
  endtask

  task automatic tick();
    bit strobe;
    @(posedge clk);
    model_edge();
    #1;
    strobe = busy && (cyc == g_edge);
    chk("s_rd_en",   bus.s_rd_en_o, strobe && mk[owner]);
    chk("s_wr_en",   bus.s_wr_en_o, strobe && !mk[owner]);
    chk("s_address", bus.s_address_o, esa);
    chk("s_wdata",   bus.s_write_data_o, esd);
    chk("m_resp",    bus.m_response_o, mresp);
    chk("m_rdata",   bus.m_read_data_o, erd);
    chk("m_overrun", bus.m_overrun_o, mov);
    if (bus.s_wr_en_o) dut_wr++;
    if (bus.m_response_o != '0) dut_resp++;
    @(negedge clk);
    bus.m_rd_en_i    = '0;
    bus.m_wr_en_i    = '0;
    bus.s_response_i = 1'b0;
    if (busy && !hold && cyc + 1 >= resp_edge) begin
      bus.s_response_i  = 1'b1;
      bus.s_read_data_i = rfix ? rval : D'($urandom);
    end else if (!busy && spur && $urandom_range(0, 7) == 0) begin
      bus.s_response_i  = 1'b1;
      bus.s_read_data_i = D'($urandom);
    end
  endtask

  task automatic req(int i, bit rd, logic [A-1:0] a, logic [D-1:0] d);
    if (rd) bus.m_rd_en_i[i] = 1'b1;
    else    bus.m_wr_en_i[i] = 1'b1;
    bus.m_address_i[i*A +: A]    = a;
    bus.m_write_data_i[i*D +: D] = d;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || mp != '0 || mresp != '0) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_bound", n < 200, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    bus.m_rd_en_i      = '0;
    bus.m_wr_en_i      = '0;
    bus.m_address_i    = '0;
    bus.m_write_data_i = '0;
    bus.s_response_i   = 1'b0;
    bus.s_read_data_i  = '0;
    do_reset();

    // single write
    dut_wr = 0;
    req(0, 0, 32'h0, 32'h41);
    tick();
    drain();
    chk("p1_wr_count", dut_wr, 1);

    // simultaneous reads from reset: master0 first
    do_reset();
    grants.delete();
    rfix = 1; rval = 32'h1;
    req(0, 1, 32'h4, '0);
    req(1, 1, 32'h4, '0);
    tick();
    drain();
    chk("p2_n", grants.size(), 2);
    chk("p2_g0", grants[0], 0);
    chk("p2_g1", grants[1], 1);

    // continuous requesting: strict rotation
    rfix = 0;
    grants.delete();
    n = 0;
    while (grants.size() < 6 && n < 300) begin
      for (int i = 0; i < N; i++)
        if (!mp[i]) req(i, 1'($urandom), A'($urandom), D'($urandom));
      tick();
      n++;
    end
    drain();
    chk("p3_bound", n < 300, 1);
    for (int k = 0; k < 6; k++) chk("p3_order", grants[k], k % 2);

    // overrun on master1
    do_reset();
    dut_wr = 0;
    req(1, 0, 32'h8, 32'h77);
    tick();
    tick();
    req(1, 0, 32'h8, 32'h99);
    tick();
    drain();
    chk("p4_ovr", bus.m_overrun_o, 2'b10);
    chk("p4_wr_count", dut_wr, 1);

    // blocking read holds master1 queued
    grants.delete();
    hold = 1; rfix = 1; rval = 32'h5A;
    dut_resp = 0;
    req(0, 1, 32'h0, '0);
    req(1, 0, 32'h0, 32'h55);
    for (int k = 0; k < 20; k++) tick();
    chk("p5_noresp", dut_resp, 0);
    hold = 0;
    drain();
    chk("p5_g0", grants[0], 0);
    chk("p5_g1", grants[1], 1);
    chk("p5_resp", dut_resp, 2);

    // reset while waiting for the UART
    hold = 1; rfix = 0;
    req(0, 0, 32'hC, 32'h12);
    for (int k = 0; k < 5; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    hold = 0;
    chk("p6_ovr", bus.m_overrun_o, 0);
    grants.delete();
    req(0, 0, 32'h10, 32'h21);
    req(1, 1, 32'h14, '0);
    tick();
    drain();
    chk("p6_g0", grants[0], 0);
    chk("p6_g1", grants[1], 1);

    // random traffic with spurious slave responses
    spur = 1;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.m_rd_en_i[i] = 1'($urandom);
          bus.m_wr_en_i[i] = 1'($urandom);
          bus.m_address_i[i*A +: A]    = A'($urandom);
          bus.m_write_data_i[i*D +: D] = D'($urandom);
        end
      end
      tick();
    end
    spur = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
